// File: rtl/multi_receiver_block_buffer.sv
// multi_receiver_block_buffer: round-robin capture of decoder words into a shared channel-tagged FIFO
// with indexed readout, per-channel sticky overflow and an idle-blink LED.
module multi_receiver_block_buffer #(
    parameter int NB_RECEIVERS = 4,
    parameter int DATA_WIDTH = 17,
    parameter int TS_WIDTH = 24,
    parameter int DEPTH = 16,
    parameter int IDLE_LOG2 = 23,
    parameter int CH_W = (NB_RECEIVERS > 1) ? $clog2(NB_RECEIVERS) : 1
) (
    input  logic                                  clk_96MHz,
    input  logic                                  reset,
    input  logic [NB_RECEIVERS*DATA_WIDTH-1:0]    decoded_data,
    input  logic [NB_RECEIVERS*TS_WIDTH-1:0]      ts_last_data,
    input  logic [NB_RECEIVERS-1:0]               data_availible,
    output logic [NB_RECEIVERS-1:0]               reset_bmc_decoder,
    input  logic [7:0]                            block_wanted_number,
    input  logic                                  read_pop,
    output logic [CH_W+TS_WIDTH+DATA_WIDTH-1:0]   block_wanted,
    output logic                                  data_ready,
    output logic [7:0]                            avl_blocks_nb,
    output logic [NB_RECEIVERS-1:0]               overflow,
    input  logic                                  clear_overflow,
    output logic                                  state_led
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = CH_W + TS_WIDTH + DATA_WIDTH;
    localparam logic [7:0] FULL_CNT = 8'(DEPTH);
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CH_W-1:0] rr_ptr, grant_ch;
    logic grant, pop, wr, drop;
    logic [NB_RECEIVERS-1:0] eligible, grant_oh;
    logic [IDLE_LOG2:0] idle_cnt;
    // a channel in its ack cycle still shows its old word, so it must not be captured twice
    assign eligible = data_availible & ~reset_bmc_decoder;
    always_comb begin
        grant = 1'b0;
        grant_ch = '0;
        for (int i = NB_RECEIVERS - 1; i >= 0; i--)
            if (eligible[(int'(rr_ptr) + i) % NB_RECEIVERS]) begin
                grant = 1'b1;
                grant_ch = CH_W'((int'(rr_ptr) + i) % NB_RECEIVERS);
            end
    end
    assign grant_oh = grant ? (NB_RECEIVERS'(1) << grant_ch) : '0;
    assign pop = read_pop && (avl_blocks_nb != 8'd0);
    assign wr = grant && ((avl_blocks_nb != FULL_CNT) || pop);
    assign drop = grant && !wr;
    always_ff @(posedge clk_96MHz)
        if (wr) mem[wr_ptr] <= {grant_ch, ts_last_data[grant_ch*TS_WIDTH +: TS_WIDTH],
                                decoded_data[grant_ch*DATA_WIDTH +: DATA_WIDTH]};
    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr_ptr <= '0;
            avl_blocks_nb <= '0;
            reset_bmc_decoder <= '0;
            block_wanted <= '0;
            data_ready <= 1'b0;
            overflow <= '0;
            idle_cnt <= '0;
            state_led <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (grant) rr_ptr <= (grant_ch == CH_W'(NB_RECEIVERS - 1)) ? '0 : grant_ch + 1'b1;
            avl_blocks_nb <= avl_blocks_nb + 8'(wr) - 8'(pop);
            reset_bmc_decoder <= grant_oh;
            overflow <= (clear_overflow ? '0 : overflow) | (drop ? grant_oh : '0);
            data_ready <= block_wanted_number < avl_blocks_nb;
            block_wanted <= (block_wanted_number < avl_blocks_nb) ?
                            mem[rd_ptr + block_wanted_number[AW-1:0]] : '0;
            idle_cnt <= (avl_blocks_nb == 8'd0) ? idle_cnt + 1'b1 : '0;
            state_led <= idle_cnt[IDLE_LOG2];
        end
    end
endmodule

// File: doc/multi_receiver_block_buffer.md
Name: multi_receiver_block_buffer

Overview:
Parametrised successor to the per-receiver decoded-block RAM. It collects decoded words and their timestamps from NB_RECEIVERS BMC decoders into one shared FIFO, arbitrating round-robin, and tags each entry with its channel. It acknowledges each capture back to the originating decoder and exposes indexed random-access readout plus an explicit pop. It adds per-channel sticky overflow flags and an idle-blink status LED. It sits between the per-receiver decoders and the readout logic of the multi-receiver tracker top.

Parameters:
NB_RECEIVERS, 4, number of decoder channels (1..16)
DATA_WIDTH, 17, decoded word width
TS_WIDTH, 24, timestamp width
DEPTH, 16, FIFO entries; power of two, 2..128
IDLE_LOG2, 23, idle counter bit driving state_led
CH_W (derived), max(1, clog2(NB_RECEIVERS)), channel tag width

Ports:
clk_96MHz  in  1  system clock
reset  in  1  asynchronous, active-high reset
decoded_data  in  NB_RECEIVERS*DATA_WIDTH  channel k at slice k
ts_last_data  in  NB_RECEIVERS*TS_WIDTH  channel k timestamp
data_availible  in  NB_RECEIVERS  level: channel k holds a word
reset_bmc_decoder  out  NB_RECEIVERS  one-cycle ack/clear to decoder k
block_wanted_number  in  8  index from oldest entry (0 = oldest)
read_pop  in  1  remove oldest entry
block_wanted  out  CH_W+TS_WIDTH+DATA_WIDTH  {channel, ts, data}
data_ready  out  1  block_wanted is valid
avl_blocks_nb  out  8  entries held
overflow  out  NB_RECEIVERS  sticky drop flag per channel
clear_overflow  in  1  clears all overflow bits
state_led  out  1  status LED

Behaviour:
- Reset (async assert, sync release) clears all registers: pointers, count, rr pointer to 0, reset_bmc_decoder=0, block_wanted=0, data_ready=0, avl_blocks_nb=0, overflow=0, idle counter=0, state_led=0. Memory contents are don't-care.
- Eligible channel k: data_availible[k]=1 and reset_bmc_decoder[k]=0 (a channel is not re-captured during its ack cycle).
- Arbitration: at most one grant per cycle. Scan eligible channels starting at rr pointer, wrapping. After granting k, rr pointer = (k+1) mod NB_RECEIVERS. With no grant, rr pointer holds.
- Capture at edge t: if not full, or read_pop is accepted in the same cycle, write {k, ts_k, data_k} at wr_ptr and increment wr_ptr mod DEPTH. If full with no pop, drop the entry and set overflow[k].
- The decoder ack is sent either way: reset_bmc_decoder[k]=1 for exactly cycle t+1.
- Pop: read_pop with count>0 increments rd_ptr. read_pop with count=0 is ignored.
- Count update per cycle:
  - +1 for a write only
  - -1 for a pop only
  - unchanged when a write and a pop occur together (including at full)
- avl_blocks_nb = count, registered. It reflects a capture or pop on the following cycle.
- Readout is registered with 1-cycle latency.
  - If block_wanted_number < count (pre-update value): block_wanted = mem[(rd_ptr + block_wanted_number) mod DEPTH] and data_ready=1.
  - Otherwise: block_wanted=0 and data_ready=0.
  - Index is relative to the oldest entry, so a pop shifts indices by one from the next cycle.
- Write and read of the same slot in the same cycle: the read returns the old contents.
- overflow is sticky. clear_overflow clears it. If clear_overflow and a new drop occur in the same cycle, the drop wins (bit stays 1).
- state_led: idle counter (IDLE_LOG2+1 bits, wrapping) increments each cycle while count==0 and clears to 0 while count>0. state_led = counter[IDLE_LOG2], registered. The LED blinks when no data is flowing and stays off while blocks are buffered.
- Pointers wrap modulo DEPTH.

Test Plan:
- Reset mid-operation: fill 5 entries, assert reset -> avl_blocks_nb=0, data_ready=0, overflow=0, no reset_bmc_decoder pulses after release until new data.
- Single capture: ch2 data=17'h1ABCD, ts=24'h000100 at t -> reset_bmc_decoder=4'b0100 at t+1 only; avl_blocks_nb=1; index 0 -> block_wanted={2,24'h000100,17'h1ABCD}, data_ready=1 one cycle later.
- Round-robin: all 4 channels held high (each re-asserted after its ack) -> grants ch0,1,2,3,0,...; FIFO order matches, no channel starved.
- Full/overflow: DEPTH=16, push 17 words from ch1 -> avl_blocks_nb=16, overflow=4'b0010, 17th still acked. Pop and push in the same cycle at full -> count stays 16, no new overflow. clear_overflow -> 0.
- Index out of range and pop: 3 entries; index 3 -> data_ready=0, block_wanted=0. Pop -> index 0 returns the former index 1. read_pop on empty -> count stays 0.
- LED: DEPTH entries empty with IDLE_LOG2=3 -> state_led toggles every 8 cycles. One capture -> LED 0 until FIFO drained.
